// File: rtl/mdio_init_seq_if.sv
// MDIO pin bundle between the init sequencer (master) and the PHY side (slave).
interface mdio_init_seq_if;
   logic MDC;
   logic MDIO_OUT;
   logic MDIO_OE;
   logic MDIO_IN;

   modport master (output MDC, output MDIO_OUT, output MDIO_OE, input MDIO_IN);
   modport slave  (input MDC, input MDIO_OUT, input MDIO_OE, output MDIO_IN);
endinterface

// File: rtl/mdio_init_seq.sv
// mdio_init_seq: writes a table of PHY register/data pairs over MDIO after reset,
// then raises COMPLETE. Each frame is 64 bits plus one idle GAP bit.
// Optional feature macro: MDIO_VERIFY_EN -- every write is followed by a read-back
// of the same register; mismatches retry up to MAX_RETRY times before ERROR.
module mdio_init_seq #(
   parameter int CLK_DIV   = 64,
   parameter int NUM_REGS  = 4,
   parameter int MAX_RETRY = 3
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [4:0]                    PHY_ADDR,
   input  logic [NUM_REGS*21-1:0]        INIT_TABLE,
   mdio_init_seq_if.master               mdio,
   output logic [$clog2(NUM_REGS+1)-1:0] INDEX,
   output logic                          COMPLETE,
   output logic                          ERROR
);

   localparam int DW = $clog2(CLK_DIV);
   localparam int IW = $clog2(NUM_REGS + 1);
   localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REGS - 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_PRE  = 3'd1;
   localparam logic [2:0] S_HDR  = 3'd2;
   localparam logic [2:0] S_TA   = 3'd3;
   localparam logic [2:0] S_DATA = 3'd4;
   localparam logic [2:0] S_GAP  = 3'd5;
   localparam logic [2:0] S_DONE = 3'd6;
   localparam logic [2:0] S_ERR  = 3'd7;

   logic [2:0]    r_state;
   logic [DW-1:0] r_div;
   logic          r_mdc;
   logic          r_out;
   logic          r_oe;
   logic          r_complete;
   logic [IW-1:0] r_index;
   logic [5:0]    r_bitCnt;
   logic [63:0]   r_shift;

   logic          w_active;
   logic          w_wrap;
   logic          w_fall;
   logic          w_rise;
   logic          w_gapEnd;
   logic          w_entryOk;
   logic          w_entryBad;
   logic          w_toDone;
   logic          w_toErr;
   logic          w_load;
   logic          w_loadRead;
   logic [IW-1:0] w_loadIdx;
   logic [20:0]   w_entry;
   logic [63:0]   w_frame;

   assign w_active = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERR);
   assign w_wrap   = w_active && (r_div == DIV_MAX);
   assign w_fall   = w_wrap && r_mdc;
   assign w_rise   = w_wrap && !r_mdc;
   assign w_gapEnd = (r_state == S_GAP) && w_fall;

`ifdef MDIO_VERIFY_EN
   localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

   logic          r_isRead;
   logic [15:0]   r_rdShift;
   logic [15:0]   r_data;
   logic [RW-1:0] r_retry;
   logic          r_error;

   assign w_entryOk  = r_isRead && (r_rdShift == r_data);
   assign w_entryBad = r_isRead && (r_rdShift != r_data) && (r_retry == RETRY_MAX);
   assign w_loadRead = w_gapEnd && !r_isRead;
   assign ERROR      = r_error;
`else
   logic w_unused;

   assign w_entryOk  = 1'b1;
   assign w_entryBad = 1'b0;
   assign w_loadRead = 1'b0;
   assign ERROR      = 1'b0;
   assign w_unused   = ^{mdio.MDIO_IN, 1'(MAX_RETRY)};
`endif

   assign w_toDone  = w_gapEnd && w_entryOk && (r_index == LAST_IDX);
   assign w_toErr   = w_gapEnd && w_entryBad;
   assign w_load    = (r_state == S_IDLE) || (w_gapEnd && !w_toDone && !w_toErr);
   assign w_loadIdx = (w_gapEnd && w_entryOk) ? r_index + 1'b1 : r_index;

   // Pick the table entry for the frame about to start (index may be advancing this cycle).
   always_comb begin
      w_entry = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (w_loadIdx == IW'(i)) w_entry = INIT_TABLE[21*i +: 21];
      end
   end

   assign w_frame = {32'hFFFF_FFFF, 2'b01, (w_loadRead ? 2'b10 : 2'b01),
                     PHY_ADDR, w_entry[20:16], 2'b10, w_entry[15:0]};

   // MDC divider: runs only while a frame is in flight, parked low otherwise.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_div <= '0;
         r_mdc <= 1'b0;
      end else if (!w_active) begin
         r_div <= '0;
         r_mdc <= 1'b0;
      end else if (w_wrap) begin
         r_div <= '0;
         r_mdc <= ~r_mdc;
      end else begin
         r_div <= r_div + 1'b1;
      end
   end

   // Frame sequencing, entry index and completion status.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state    <= S_IDLE;
         r_index    <= '0;
         r_complete <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE:  r_state <= S_PRE;
            S_PRE:   if (w_fall && r_bitCnt == 6'd31) r_state <= S_HDR;
            S_HDR:   if (w_fall && r_bitCnt == 6'd45) r_state <= S_TA;
            S_TA:    if (w_fall && r_bitCnt == 6'd47) r_state <= S_DATA;
            S_DATA:  if (w_fall && r_bitCnt == 6'd63) r_state <= S_GAP;
            S_GAP: begin
               if (w_toDone)      r_state <= S_DONE;
               else if (w_toErr)  r_state <= S_ERR;
               else if (w_gapEnd) r_state <= S_PRE;
            end
            default: r_state <= r_state;
         endcase
         if (w_gapEnd && w_entryOk) r_index <= r_index + 1'b1;
         if (w_toDone) r_complete <= 1'b1;
      end
   end

   // Serialise the frame: pins only change on the MDC falling edge (or the very first bit).
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_out    <= 1'b1;
         r_oe     <= 1'b0;
         r_shift  <= '0;
         r_bitCnt <= '0;
`ifdef MDIO_VERIFY_EN
         r_isRead <= 1'b0;
         r_data   <= '0;
`endif
      end else if (w_load) begin
         r_out    <= w_frame[63];
         r_oe     <= 1'b1;
         r_shift  <= {w_frame[62:0], 1'b0};
         r_bitCnt <= '0;
`ifdef MDIO_VERIFY_EN
         r_isRead <= w_loadRead;
         r_data   <= w_entry[15:0];
`endif
      end else if (w_fall) begin
         if (r_state == S_GAP) begin
            r_out <= 1'b1;
            r_oe  <= 1'b0;
         end else if (r_bitCnt == 6'd63) begin
            r_out <= 1'b1;
            r_oe  <= 1'b1;
         end else begin
            r_out    <= r_shift[63];
            r_shift  <= {r_shift[62:0], 1'b0};
            r_bitCnt <= r_bitCnt + 6'd1;
`ifdef MDIO_VERIFY_EN
            r_oe     <= !(r_isRead && r_bitCnt >= 6'd45);
`else
            r_oe     <= 1'b1;
`endif
         end
      end
   end

`ifdef MDIO_VERIFY_EN
   // Read-back capture on MDC rise and retry/error bookkeeping at the end of each read.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_rdShift <= '0;
         r_retry   <= '0;
         r_error   <= 1'b0;
      end else begin
         if (w_rise && r_state == S_DATA && !r_oe) r_rdShift <= {r_rdShift[14:0], mdio.MDIO_IN};
         if (w_gapEnd && r_isRead) begin
            if (w_entryOk)       r_retry <= '0;
            else if (!w_entryBad) r_retry <= r_retry + 1'b1;
         end
         if (w_toErr) r_error <= 1'b1;
      end
   end
`endif

   assign mdio.MDC      = r_mdc;
   assign mdio.MDIO_OUT = r_out;
   assign mdio.MDIO_OE  = r_oe;
   assign INDEX         = r_index;
   assign COMPLETE      = r_complete;

endmodule

// File: tb/tb_mdio_init_seq.sv
// Self-checking bench for mdio_init_seq: a PHY model answers frames, a monitor
// captures frames on MDC rise and compares them against a scoreboard queue.
module tb_mdio_init_seq;

   localparam int CLK_DIV   = 2;
   localparam int NUM_REGS  = 2;
   localparam int MAX_RETRY = 3;
   localparam int IW        = $clog2(NUM_REGS + 1);
   localparam int BIT_CYC   = 2 * CLK_DIV;
`ifdef MDIO_VERIFY_EN
   localparam int ENTRY1_FRAME = 2;
`else
   localparam int ENTRY1_FRAME = 1;
`endif

   typedef struct packed {
      logic [63:0] frame;
      logic [63:0] oe;
   } frame_t;

   logic                   CLK = 1'b0;
   logic                   RST = 1'b1;
   logic [4:0]             PHY_ADDR = '0;
   logic [NUM_REGS*21-1:0] INIT_TABLE = '0;
   logic [IW-1:0]          INDEX;
   logic                   COMPLETE;
   logic                   ERROR;

   mdio_init_seq_if mdioIf();

   mdio_init_seq #(.CLK_DIV(CLK_DIV), .NUM_REGS(NUM_REGS), .MAX_RETRY(MAX_RETRY)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .PHY_ADDR   (PHY_ADDR),
      .INIT_TABLE (INIT_TABLE),
      .mdio       (mdioIf.master),
      .INDEX      (INDEX),
      .COMPLETE   (COMPLETE),
      .ERROR      (ERROR)
   );

   always #5 CLK = ~CLK;

   frame_t      expQ[$];
   int          checks = 0;
   int          errors = 0;
   int          cycleCnt;
   logic [15:0] phyRegs[32];
   int          phyBad[32];

   // Clock edges elapsed since reset release; edge 1 is the first after release.
   always @(posedge CLK or posedge RST) begin
      if (RST) cycleCnt <= 0;
      else     cycleCnt <= cycleCnt + 1;
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic frame_t mkFrame(input bit isRead, input logic [4:0] phy,
                                      input logic [4:0] regad, input logic [15:0] data);
      frame_t f;
      f.frame = {32'hFFFF_FFFF, 2'b01, (isRead ? 2'b10 : 2'b01), phy, regad, 2'b10, data};
      f.oe    = isRead ? {{46{1'b1}}, 18'd0} : {64{1'b1}};
      return f;
   endfunction

   // Reference model: which frames the sequence must emit and how it must end.
   task automatic pushModel(output int nFrames, output bit expErr, output int expIdx);
      int          bad[32];
      logic [20:0] e;
      bit          ok;
      for (int r = 0; r < 32; r++) bad[r] = phyBad[r];
      nFrames = 0;
      expErr  = 1'b0;
      expIdx  = NUM_REGS;
      for (int i = 0; i < NUM_REGS; i++) begin
         e = INIT_TABLE[21*i +: 21];
`ifdef MDIO_VERIFY_EN
         ok = 1'b0;
         for (int a = 0; a <= MAX_RETRY && !ok; a++) begin
            expQ.push_back(mkFrame(1'b0, PHY_ADDR, e[20:16], e[15:0]));
            expQ.push_back(mkFrame(1'b1, PHY_ADDR, e[20:16], 16'h0000));
            nFrames += 2;
            if (bad[e[20:16]] > 0) bad[e[20:16]]--;
            else ok = 1'b1;
         end
         if (!ok) begin
            expErr = 1'b1;
            expIdx = i;
            break;
         end
`else
         ok = 1'b1;
         expQ.push_back(mkFrame(1'b0, PHY_ADDR, e[20:16], e[15:0]));
         nFrames += ok ? 1 : 0;
`endif
      end
   endtask

   // PHY model: decodes frames on MDC rise, stores writes, answers reads.
   initial begin
      int          bitIdx;
      logic [63:0] sh;
      bit          rd;
      logic [4:0]  ra;
      logic [15:0] rdata;
      logic        prevMdc;
      for (int r = 0; r < 32; r++) phyRegs[r] = '0;
      mdioIf.MDIO_IN = 1'b1;
      bitIdx = 0; sh = '0; rd = 1'b0; ra = '0; rdata = '0; prevMdc = 1'b0;
      forever begin
         @(negedge CLK);
         if (RST) begin
            bitIdx = 0;
            rd     = 1'b0;
         end else if (mdioIf.MDC && !prevMdc) begin
            sh = {sh[62:0], mdioIf.MDIO_OUT};
            if (bitIdx == 45) begin
               rd = (sh[11:10] == 2'b10);
               ra = sh[4:0];
               if (rd) begin
                  if (phyBad[ra] > 0) begin
                     phyBad[ra]--;
                     rdata = ~phyRegs[ra];
                  end else begin
                     rdata = phyRegs[ra];
                  end
               end
            end
            if (rd && bitIdx >= 45 && bitIdx <= 62)
               mdioIf.MDIO_IN = (bitIdx == 45) ? 1'b1 : (bitIdx == 46) ? 1'b0 : rdata[62-bitIdx];
            else
               mdioIf.MDIO_IN = 1'($urandom);
            if (bitIdx == 63 && !rd) phyRegs[ra] = sh[15:0];
            bitIdx = (bitIdx == 64) ? 0 : bitIdx + 1;
         end
         prevMdc = mdioIf.MDC;
      end
   end

   int          monBit;
   logic [63:0] monFrame;
   logic [63:0] monOe;
   logic        monPrevMdc;
   logic        monPrevOut;
   logic        monPrevOe;
   int          lastRise;
   frame_t      expF;

   // Monitor: timing checks plus frame capture and scoreboard comparison.
   always @(negedge CLK) begin
      if (RST) begin
         monBit   = 0;
         lastRise = 0;
      end else begin
         if (mdioIf.MDIO_OUT !== monPrevOut || mdioIf.MDIO_OE !== monPrevOe)
            checkOutput("pin change on MDC fall", 64'((monPrevMdc && !mdioIf.MDC) || cycleCnt == 1), 64'd1);
         if (mdioIf.MDC && !monPrevMdc) begin
            checkOutput("MDC rise spacing", 64'(cycleCnt - lastRise),
                        64'((lastRise == 0) ? CLK_DIV + 1 : BIT_CYC));
            lastRise = cycleCnt;
            if (monBit < 64) begin
               monFrame = {monFrame[62:0], mdioIf.MDIO_OUT};
               monOe    = {monOe[62:0], mdioIf.MDIO_OE};
               monBit++;
            end else begin
               checkOutput("gap bit OE/OUT", 64'({mdioIf.MDIO_OE, mdioIf.MDIO_OUT}), 64'd3);
               checkOutput("frame expected", 64'(expQ.size() != 0), 64'd1);
               if (expQ.size() != 0) begin
                  expF = expQ.pop_front();
                  checkOutput("frame bits", monFrame & expF.oe, expF.frame & expF.oe);
                  checkOutput("frame OE pattern", monOe, expF.oe);
               end
               monBit = 0;
            end
         end
      end
      monPrevMdc = mdioIf.MDC;
      monPrevOut = mdioIf.MDIO_OUT;
      monPrevOe  = mdioIf.MDIO_OE;
   end

   task automatic applyStimulus(input int run, input bit interrupt);
      int         nFrames, expIdx, expCyc, target;
      bit         expErr;
      logic [4:0] regs[NUM_REGS];
      RST = 1'b1;
      expQ.delete();
      for (int r = 0; r < 32; r++) phyBad[r] = 0;
      if (run == 0) begin
         PHY_ADDR   = 5'h01;
         INIT_TABLE = {5'h04, 16'h01A0, 5'h00, 16'h1140};
      end else begin
         PHY_ADDR = 5'($urandom);
         regs[0]  = 5'($urandom);
         for (int i = 1; i < NUM_REGS; i++) regs[i] = regs[i-1] ^ 5'($urandom_range(1, 31));
         for (int i = 0; i < NUM_REGS; i++) INIT_TABLE[21*i +: 21] = {regs[i], 16'($urandom)};
`ifdef MDIO_VERIFY_EN
         if (run == 2) phyBad[regs[$urandom_range(0, NUM_REGS-1)]] = 1;
         if (run == 3) phyBad[regs[1]] = MAX_RETRY + 1;
`endif
      end
      pushModel(nFrames, expErr, expIdx);
`ifndef MDIO_VERIFY_EN
      if (run == 0) begin
         expQ.delete();
         expQ.push_back('{frame: 64'hFFFF_FFFF_5082_1140, oe: {64{1'b1}}});
         expQ.push_back('{frame: 64'hFFFF_FFFF_5092_01A0, oe: {64{1'b1}}});
      end
`endif
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      if (interrupt) begin
         target = 1 + (ENTRY1_FRAME * 65 + 52) * BIT_CYC + CLK_DIV;
         for (int c = 0; c < 20000 && cycleCnt < target; c++) @(negedge CLK);
         checkOutput("INDEX before interrupt", 64'(INDEX), 64'd1);
         RST = 1'b1;
         #1;
         checkOutput("async reset MDC", 64'(mdioIf.MDC), 64'd0);
         checkOutput("async reset OE", 64'(mdioIf.MDIO_OE), 64'd0);
         checkOutput("async reset OUT", 64'(mdioIf.MDIO_OUT), 64'd1);
         checkOutput("async reset INDEX", 64'(INDEX), 64'd0);
         expQ.delete();
         repeat (3) @(negedge CLK);
         pushModel(nFrames, expErr, expIdx);
         RST = 1'b0;
      end
      expCyc = 1 + nFrames * 65 * BIT_CYC;
      for (int c = 0; c < expCyc + 100 && !(COMPLETE || ERROR); c++) @(negedge CLK);
      checkOutput("sequence ended", 64'(COMPLETE || ERROR), 64'd1);
      checkOutput("end cycle", 64'(cycleCnt), 64'(expCyc));
      checkOutput("COMPLETE", 64'(COMPLETE), 64'(!expErr));
      checkOutput("ERROR", 64'(ERROR), 64'(expErr));
      checkOutput("final INDEX", 64'(INDEX), 64'(expIdx));
      checkOutput("idle pins MDC/OE/OUT", 64'({mdioIf.MDC, mdioIf.MDIO_OE, mdioIf.MDIO_OUT}), 64'b001);
      checkOutput("frames left in queue", 64'(expQ.size()), 64'd0);
      repeat (20) @(negedge CLK);
      checkOutput("sticky status", 64'({COMPLETE, ERROR, mdioIf.MDC}), 64'({!expErr, expErr, 1'b0}));
   endtask

   initial begin
      repeat (3) @(negedge CLK);
      checkOutput("reset MDC", 64'(mdioIf.MDC), 64'd0);
      checkOutput("reset OUT", 64'(mdioIf.MDIO_OUT), 64'd1);
      checkOutput("reset OE", 64'(mdioIf.MDIO_OE), 64'd0);
      checkOutput("reset COMPLETE", 64'(COMPLETE), 64'd0);
      checkOutput("reset ERROR", 64'(ERROR), 64'd0);
      checkOutput("reset INDEX", 64'(INDEX), 64'd0);
      applyStimulus(0, 1'b0);
      applyStimulus(1, 1'b1);
      applyStimulus(2, 1'b0);
      applyStimulus(3, 1'b0);
      applyStimulus(4, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mdio_init_seq.md
# mdio_init_seq

Parametrised MDIO management-frame sequencer that succeeds the fixed single-purpose PHY initialiser. It sits between the Ethernet core's management port and the PCS/PMA MDIO pins and runs at the 125 MHz user clock. After reset it writes a table of `NUM_REGS` register/data pairs to the PHY, optionally reading each one back to verify it. It then raises `COMPLETE`, which the top level uses to hand MDC/MDIO to the SiTCP core.

## Interface
Parameters:
- `CLK_DIV`, default 64: MDC half-period in `CLK` cycles. Must be ≥2. MDC frequency = CLK/(2·CLK_DIV).
- `NUM_REGS`, default 4: number of table entries. Must be ≥1.
- `MAX_RETRY`, default 3: verify retries per entry. Used only with `MDIO_VERIFY_EN`.

Ports. One clock; reset is asynchronous and active-high.
- `CLK` in 1: system clock (125 MHz).
- `RST` in 1: asynchronous, active-high reset; driven from ~resetdone of the PCS/PMA.
- `PHY_ADDR` in 5: target PHY address, static after reset.
- `INIT_TABLE` in NUM_REGS·21: entry i = bits [21i+20:21i] = {regad[4:0], data[15:0]}. Entry 0 is sent first.
- `MDC` out 1: management clock.
- `MDIO_OUT` out 1: serial data to PHY.
- `MDIO_OE` out 1: 1 = sequencer drives MDIO.
- `MDIO_IN` in 1: serial data from PHY.
- `INDEX` out clog2(NUM_REGS+1): current entry number; equals NUM_REGS when done.
- `COMPLETE` out 1: sequence finished successfully; level output, sticky until reset.
- `ERROR` out 1: verify failed after retries; sticky until reset.

## Operation
- Bit timing:
  - A divider counts 0..CLK_DIV−1 and toggles MDC on wrap.
  - One bit period = 2·CLK_DIV cycles, starting at an MDC falling edge.
  - `MDIO_OUT`/`MDIO_OE` update only on the cycle MDC goes low.
  - `MDIO_IN` is sampled on the cycle MDC goes high.
- Write frame (64 bits, MSB first): 32×'1' preamble, ST=01, OP=01, PHY_ADDR, regad, TA=10, data[15:0].
- Read frame: OP=10. TA and data bits use `MDIO_OE`=0. The 16 data bits are sampled into a shift register.
- Each frame is followed by one GAP bit with `MDIO_OE`=1 and `MDIO_OUT`=1.
- States:
  - IDLE goes to PRE on the first cycle after reset release.
  - PRE → HDR (14 bits: ST, OP, PHYAD, REGAD) → TA → DATA → GAP.
  - From GAP: go to the next entry's PRE, or to DONE after entry NUM_REGS−1.
  - DONE: sets `COMPLETE`=1, `MDC`=0, `MDIO_OE`=0, `MDIO_OUT`=1; stays there.
  - ERR: sets `ERROR`=1, `COMPLETE`=0; same pin levels as DONE; stays there.
- `INDEX` increments at the end of the GAP that closes an entry's last frame.
- `PHY_ADDR` and `INIT_TABLE` are sampled at the start of each frame (PRE entry).

## Timing
- Reset values (asynchronous): `MDC`=0, `MDIO_OUT`=1, `MDIO_OE`=0, `COMPLETE`=0, `ERROR`=0, `INDEX`=0, state=IDLE, divider=0.
- First MDC rising edge occurs CLK_DIV+1 cycles after `RST` deasserts.
- Without verify, `COMPLETE` rises exactly 1 + NUM_REGS·65·2·CLK_DIV cycles after `RST` falls.
  - Defaults: 33 281 cycles.
- With verify and no retries, the sequence is NUM_REGS·130 bit periods.
- Each retry adds 130 bit periods: write plus read.
- RST asserted mid-frame: all outputs return to reset values within the same cycle (asynchronous). The sequence restarts from entry 0 on release. No partial frame resumes.
- `MDIO_IN` is ignored whenever `MDIO_OE`=1.
- The TA bit 0 from the PHY is not checked.

## Configuration
- `MDIO_VERIFY_EN` defined:
  - After each write frame + GAP, a read frame of the same register is issued.
  - If the read data ≠ the table data, the write/read pair repeats, up to MAX_RETRY retries.
  - If the data still mismatches, go to ERR.
- `MDIO_VERIFY_EN` undefined:
  - Only write frames are generated and the read path is removed.
  - `ERROR` is tied to 0.
  - `MAX_RETRY` is unused.

## Test plan
- CLK_DIV=2, NUM_REGS=2, PHY_ADDR=5'h01, entries {5'h00, 16'h1140} and {5'h04, 16'h01A0}, no verify:
  - capture bits on MDC rise → frames 0xFFFFFFFF_5082_1140 and 0xFFFFFFFF_5092_01A0;
  - `COMPLETE`=1 at cycle 1+2·65·4 = 521.
- Defaults, no verify → `COMPLETE` rises at cycle 33 281; `MDC` period is 128 cycles; `MDIO_OUT` changes only on MDC falls.
- Assert RST for 3 cycles during entry 1 DATA → `MDC`=0, `MDIO_OE`=0, `INDEX`=0 immediately; after release, the next captured frame is entry 0.
- `MDIO_VERIFY_EN`, PHY model echoes the written data → read frames show OE=0 from TA through data; `COMPLETE`=1 after NUM_REGS·130 bit periods; `ERROR`=0.
- `MDIO_VERIFY_EN`, MAX_RETRY=3, PHY returns 16'h0000 for regad 4 → 4 write/read pairs for entry 1, then `ERROR`=1, `COMPLETE`=0, `INDEX`=1, pins idle.
- `MDIO_VERIFY_EN`, PHY mismatches once then matches → exactly one retry; `COMPLETE`=1; `ERROR`=0.
